// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational read with WB write bypass,
// synchronous masked writes, and the 64-bit cycle / retired-instruction counters.
module csr_regfile #(
  parameter logic [31:0] MISA_VAL  = 32'h40000100,
  parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_read_addr_ID,
  output logic [31:0] csr_out_ID,
  output logic        csr_illegal_ID,
  input  logic        csr_write_en_WB,
  input  logic [11:0] csr_dest_WB,
  input  logic [31:0] csr_data_WB,
  input  logic        instret_WB,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [31:0] wdata_s;
  logic [31:0] stored_s;
  logic        bypass_s;

  // The same mask feeds both the bypass and the stored value so they can never disagree.
  function automatic logic [31:0] apply_mask(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] res;
    case (addr)
      A_MSTATUS: res = data & 32'h00000088;
      A_MTVEC:   res = {data[31:2], 2'b00};
      A_MEPC:    res = {data[31:1], 1'b0};
      default:   res = data;
    endcase
    return res;
  endfunction

  function automatic logic is_writable(input logic [11:0] addr);
    logic res;
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Decode the stored value for the ID read address.
  always_comb begin
    stored_s       = 32'd0;
    csr_illegal_ID = 1'b0;
    case (csr_read_addr_ID)
      A_MSTATUS:             stored_s = {24'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
      A_MISA:                stored_s = MISA_VAL;
      A_MIE:                 stored_s = mie_r;
      A_MTVEC:               stored_s = mtvec_r;
      A_MSCRATCH:            stored_s = mscratch_r;
      A_MEPC:                stored_s = mepc_r;
      A_MCAUSE:              stored_s = mcause_r;
      A_MTVAL:               stored_s = mtval_r;
      A_MCYCLE,   A_CYCLE:   stored_s = mcycle_r[31:0];
      A_MCYCLEH,  A_CYCLEH:  stored_s = mcycle_r[63:32];
      A_MINSTRET, A_INSTRET: stored_s = minstret_r[31:0];
      A_MINSTRETH, A_INSTRETH: stored_s = minstret_r[63:32];
      default: begin
        stored_s       = 32'd0;
        csr_illegal_ID = 1'b1;
      end
    endcase
  end

  // Forward the in-flight WB write when it targets the address being read.
  always_comb begin
    wdata_s  = apply_mask(csr_dest_WB, csr_data_WB);
    bypass_s = csr_write_en_WB && (csr_dest_WB == csr_read_addr_ID) &&
               is_writable(csr_dest_WB) && !rst;
    if (bypass_s) begin
      csr_out_ID = wdata_s;
    end else begin
      csr_out_ID = stored_s;
    end
  end

  // State update: reset beats write, write beats increment (a written half gets no carry).
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= 32'd0;
      mtvec_r        <= MTVEC_RST;
      mscratch_r     <= 32'd0;
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
      mtval_r        <= 32'd0;
      mcycle_r       <= 64'd0;
      minstret_r     <= 64'd0;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
      if (instret_WB) begin
        minstret_r <= minstret_r + 64'd1;
      end
      if (csr_write_en_WB) begin
        case (csr_dest_WB)
          A_MSTATUS: begin
            mstatus_mie_r  <= wdata_s[3];
            mstatus_mpie_r <= wdata_s[7];
          end
          A_MIE:       mie_r      <= wdata_s;
          A_MTVEC:     mtvec_r    <= wdata_s;
          A_MSCRATCH:  mscratch_r <= wdata_s;
          A_MEPC:      mepc_r     <= wdata_s;
          A_MCAUSE:    mcause_r   <= wdata_s;
          A_MTVAL:     mtval_r    <= wdata_s;
          A_MCYCLE:    mcycle_r   <= {mcycle_r[63:32], wdata_s};
          A_MCYCLEH:   mcycle_r   <= {wdata_s, mcycle_r[31:0]};
          A_MINSTRET:  minstret_r <= {minstret_r[63:32], wdata_s};
          A_MINSTRETH: minstret_r <= {wdata_s, minstret_r[31:0]};
          default: ;
        endcase
      end
    end
  end

  assign mtvec_out = mtvec_r;
  assign mepc_out  = mepc_r;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed plan steps followed by random
// traffic, all compared against a behavioural CSR model kept in the bench.
module tb_csr_regfile;

  localparam logic [31:0] MISA_VAL  = 32'h40000100;
  localparam logic [31:0] MTVEC_RST = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_read_addr_ID;
  logic [31:0] csr_out_ID;
  logic        csr_illegal_ID;
  logic        csr_write_en_WB;
  logic [11:0] csr_dest_WB;
  logic [31:0] csr_data_WB;
  logic        instret_WB;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;

  int errors = 0;
  int checks = 0;

  // Model state: plain registers by address, counters as 64-bit integers.
  logic [31:0] regs [int];
  logic [63:0] cyc;
  logic [63:0] ins;

  logic [11:0] addr_pool [0:17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                    12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h302};

  csr_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .csr_read_addr_ID (csr_read_addr_ID),
    .csr_out_ID       (csr_out_ID),
    .csr_illegal_ID   (csr_illegal_ID),
    .csr_write_en_WB  (csr_write_en_WB),
    .csr_dest_WB      (csr_dest_WB),
    .csr_data_WB      (csr_data_WB),
    .instret_WB       (instret_WB),
    .mtvec_out        (mtvec_out),
    .mepc_out         (mepc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_mask(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h300) return d & 32'h00000088;
    if (a == 12'h305) return d & 32'hFFFFFFFC;
    if (a == 12'h341) return d & 32'hFFFFFFFE;
    return d;
  endfunction

  function automatic bit m_is_counter_w(input logic [11:0] a);
    return (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82);
  endfunction

  function automatic bit m_writable(input logic [11:0] a);
    return regs.exists(int'(a)) || m_is_counter_w(a);
  endfunction

  function automatic logic [31:0] m_stored(input logic [11:0] a);
    if (regs.exists(int'(a))) return regs[int'(a)];
    if (a == 12'h301) return MISA_VAL;
    if (a == 12'hB00 || a == 12'hC00) return cyc[31:0];
    if (a == 12'hB80 || a == 12'hC80) return cyc[63:32];
    if (a == 12'hB02 || a == 12'hC02) return ins[31:0];
    if (a == 12'hB82 || a == 12'hC82) return ins[63:32];
    return 32'd0;
  endfunction

  function automatic bit m_illegal(input logic [11:0] a);
    return !(m_writable(a) || a == 12'h301 || a == 12'hC00 || a == 12'hC80 ||
             a == 12'hC02 || a == 12'hC82);
  endfunction

  task automatic model_reset();
    regs.delete();
    regs[32'h300] = 32'd0; regs[32'h304] = 32'd0; regs[32'h305] = MTVEC_RST;
    regs[32'h340] = 32'd0; regs[32'h341] = 32'd0; regs[32'h342] = 32'd0;
    regs[32'h343] = 32'd0;
    cyc = 64'd0;
    ins = 64'd0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [63:0] c, n;
    if (rst) begin
      model_reset();
    end else begin
      c = cyc + 64'd1;
      n = ins + (instret_WB ? 64'd1 : 64'd0);
      if (csr_write_en_WB) begin
        if (regs.exists(int'(csr_dest_WB))) regs[int'(csr_dest_WB)] = m_mask(csr_dest_WB, csr_data_WB);
        case (csr_dest_WB)
          12'hB00: c = {cyc[63:32], csr_data_WB};
          12'hB80: c = {csr_data_WB, cyc[31:0]};
          12'hB02: n = {ins[63:32], csr_data_WB};
          12'hB82: n = {csr_data_WB, ins[31:0]};
          default: ;
        endcase
      end
      cyc = c;
      ins = n;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp;
    if (csr_write_en_WB && csr_dest_WB == csr_read_addr_ID && m_writable(csr_dest_WB) && !rst)
      exp = m_mask(csr_dest_WB, csr_data_WB);
    else
      exp = m_stored(csr_read_addr_ID);
    check($sformatf("out@%h", csr_read_addr_ID), csr_out_ID, exp);
    check($sformatf("illegal@%h", csr_read_addr_ID), {31'd0, csr_illegal_ID},
          {31'd0, m_illegal(csr_read_addr_ID)});
    check("mtvec_out", mtvec_out, regs[32'h305]);
    check("mepc_out", mepc_out, regs[32'h341]);
  endtask

  task automatic drive(input logic r, input logic [11:0] ra, input logic we,
                       input logic [11:0] dst, input logic [31:0] d, input logic inst);
    rst = r; csr_read_addr_ID = ra; csr_write_en_WB = we;
    csr_dest_WB = dst; csr_data_WB = d; instret_WB = inst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [11:0] ra);
    drive(1'b0, ra, 1'b0, 12'h000, 32'd0, 1'b0);
    check_model();
  endtask

  initial begin
    @(negedge clk);
    drive(1'b1, 12'h000, 1'b0, 12'h000, 32'd0, 1'b0);
    tick();
    tick();

    idle_read(12'h305); check("rst_mtvec", csr_out_ID, MTVEC_RST);
    idle_read(12'h301); check("misa", csr_out_ID, 32'h40000100);
    idle_read(12'h7C0); check("illegal_out", csr_out_ID, 32'd0);
    check("illegal_flag", {31'd0, csr_illegal_ID}, 32'd1);

    drive(1'b0, 12'h340, 1'b1, 12'h340, 32'hDEADBEEF, 1'b0);
    check_model(); check("bypass", csr_out_ID, 32'hDEADBEEF);
    tick();
    idle_read(12'h340); check("stored", csr_out_ID, 32'hDEADBEEF);

    drive(1'b0, 12'h300, 1'b1, 12'h300, 32'hFFFFFFFF, 1'b0); check_model(); tick();
    idle_read(12'h300); check("mstatus_mask", csr_out_ID, 32'h00000088);
    drive(1'b0, 12'h341, 1'b1, 12'h341, 32'h00001003, 1'b0); check_model(); tick();
    idle_read(12'h341); check("mepc_out", mepc_out, 32'h00001002);

    drive(1'b0, 12'hB00, 1'b1, 12'hB00, 32'hFFFFFFFF, 1'b0); check_model(); tick();
    drive(1'b0, 12'hB80, 1'b1, 12'hB80, 32'h00000000, 1'b0); check_model(); tick();
    idle_read(12'hB00); check("mcycle_pre", csr_out_ID, 32'hFFFFFFFF);
    tick();
    idle_read(12'hB00); check("mcycle_wrap", csr_out_ID, 32'd0);
    idle_read(12'hB80); check("mcycleh_carry", csr_out_ID, 32'd1);
    drive(1'b0, 12'hC00, 1'b1, 12'hC00, 32'd5, 1'b0); check_model(); tick();
    idle_read(12'hC00); check("cycle_ro", csr_out_ID, 32'd1);

    drive(1'b1, 12'h000, 1'b0, 12'h000, 32'd0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 12'hB02, 1'b0, 12'h000, 32'd0, 1'b1); check_model(); tick();
    end
    idle_read(12'hB02); check("minstret3", csr_out_ID, 32'd3);
    drive(1'b0, 12'hB02, 1'b1, 12'hB02, 32'h00000100, 1'b1); check_model(); tick();
    idle_read(12'hB02); check("minstret_wr", csr_out_ID, 32'h00000100);

    drive(1'b0, 12'h340, 1'b1, 12'h340, 32'd1, 1'b0); tick();
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 12'hB00, 1'b0, 12'h000, 32'd0, 1'b0); tick();
    end
    drive(1'b1, 12'h340, 1'b1, 12'h340, 32'd7, 1'b1);
    check_model(); check("rst_no_bypass", csr_out_ID, 32'd1);
    tick();
    idle_read(12'h340); check("rst_mscratch", csr_out_ID, 32'd0);
    idle_read(12'h305); check("rst_mtvec2", csr_out_ID, MTVEC_RST);
    idle_read(12'hB00); check("rst_mcycle", csr_out_ID, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] ra, dst;
      logic [31:0] d;
      ra  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 17)];
      dst = ($urandom_range(0, 1) == 0) ? ra : addr_pool[$urandom_range(0, 17)];
      d   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      drive(($urandom_range(0, 49) == 0), ra, 1'($urandom), dst, d, 1'($urandom));
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
